// File: rtl/cla_pkg.sv
// Shared constants and parameter checks for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_MAX_GROUP = 16;
  localparam int CLA_MIN_GROUP = 2;

  // WIDTH must split evenly into lookahead groups of a supported size.
  function automatic bit cla_params_ok(input int width, input int group);
    return (group >= CLA_MIN_GROUP) && (group <= CLA_MAX_GROUP) &&
           (width > 0) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// Group generate/propagate for one GROUP-bit lookahead block (purely combinational).
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0] g_i,
  input  logic [GROUP-1:0] p_i,
  output logic             grp_g_o,
  output logic             grp_p_o
);

  if (GROUP < CLA_MIN_GROUP || GROUP > CLA_MAX_GROUP) begin : g_bad_group
    $error("cla_group: GROUP out of range");
  end

  // NOTE: combinational blocks use blocking '=' so each loop step sees the previous one;
  // sequential state elsewhere uses '<='.
  always_comb begin
    grp_g_o = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      grp_g_o = g_i[i] | (p_i[i] & grp_g_o);
    end
  end

  assign grp_p_o = &p_i;

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_OVF_DETECT_EN to register a signed-overflow flag alongside the sum.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;

  if (!cla_params_ok(WIDTH, GROUP)) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP, GROUP in 2..16");
  end

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic             cin_eff;
  } stage1_t;

  logic             v1_q, v2_q;
  logic             adv1, adv2;
  logic [WIDTH-1:0] b_eff, p_d, g_d;
  logic [NG-1:0]    grp_g_d, grp_p_d;
  stage1_t          s1_d, s1_q;
  logic [NG:0]      cg;
  logic [WIDTH-1:0] bc;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  assign adv2     = !v2_q | out_ready;
  assign adv1     = !v1_q | adv2;
  assign in_ready = adv1;

  // Subtraction is a + ~b + 1, so the caller's carry-in is overridden.
  assign b_eff = sub ? ~b : b;
  assign p_d   = a ^ b_eff;
  assign g_d   = a & b_eff;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .g_i     (g_d[k*GROUP +: GROUP]),
      .p_i     (p_d[k*GROUP +: GROUP]),
      .grp_g_o (grp_g_d[k]),
      .grp_p_o (grp_p_d[k])
    );
  end

  assign s1_d = '{p: p_d, g: g_d, grp_g: grp_g_d, grp_p: grp_p_d, cin_eff: sub | cin};

  // Group carries come from the lookahead terms; bit carries ripple only inside a group.
  always_comb begin
    cg    = '0;
    cg[0] = s1_q.cin_eff;
    for (int k = 0; k < NG; k++) begin
      cg[k+1] = s1_q.grp_g[k] | (s1_q.grp_p[k] & cg[k]);
    end
    bc    = '0;
    bc[0] = cg[0];
    for (int i = 1; i < WIDTH; i++) begin
      if ((i % GROUP) == 0) bc[i] = cg[i/GROUP];
      else                  bc[i] = s1_q.g[i-1] | (s1_q.p[i-1] & bc[i-1]);
    end
  end

  assign sum_d  = s1_q.p ^ bc;
  assign cout_d = cg[NG];

  // NOTE: reset is synchronous (sampled on the clock edge), and it clears the data
  // registers as well so outputs read zero straight after reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      s1_q   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      if (adv1)             v1_q <= in_valid;
      if (adv1 && in_valid) s1_q <= s1_d;
      if (adv2)             v2_q <= v1_q;
      if (adv2 && v1_q) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

`ifdef CLA_OVF_DETECT_EN
  logic ovf_d, ovf_q;
  assign ovf_d = bc[WIDTH-1] ^ cg[NG];

  always_ff @(posedge clock) begin
    if (!resetn)           ovf_q <= 1'b0;
    else if (adv2 && v1_q) ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and table-driven bench for cla_pipe_adder (32/8 instance plus a 16/4 instance).
module tb_cla_pipe_adder;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, sub, cout, ovf;

  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [15:0] p_a, p_b, p_sum;
  logic        p_cin, p_sub, p_cout, p_ovf;

  int errors = 0;
  int checks = 0;
  int accepted, delivered;
  logic [33:0] exp_q[$];
  logic [16:0] p_exp_q[$];

  always #5 clock = ~clock;

  cla_pipe_adder #(.WIDTH(32), .GROUP(8)) u_dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (
    .clock(clock), .resetn(resetn), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .a(p_a), .b(p_b), .cin(p_cin), .sub(p_sub), .out_valid(p_out_valid),
    .out_ready(p_out_ready), .sum(p_sum), .cout(p_cout), .ovf(p_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result {ovf, cout, sum} computed from the arithmetic definition.
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mcin, input logic msub);
    logic [31:0] be;
    logic [32:0] r;
    logic        ov;
    be = msub ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, be} + {32'd0, (msub | mcin)};
    ov = (ma[31] == be[31]) && (r[31] != ma[31]);
`ifdef CLA_OVF_DETECT_EN
    return {ov, r};
`else
    return {1'b0 & ov, r};
`endif
  endfunction

  // Inputs are set 1 unit after an edge; sample 1 unit later, then advance one clock.
  task automatic cycle();
    logic [33:0] e;
    #1;
    if (out_valid && out_ready) begin
      delivered++;
      if (exp_q.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("stream_sum", sum, e[31:0]);
        check("stream_cout", cout, e[32]);
        check("stream_ovf", ovf, e[33]);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(a, b, cin, sub));
      accepted++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] held;
    logic [15:0] pb_eff;
    logic [16:0] p_e;
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    p_in_valid = 1'b0; p_out_ready = 1'b1; p_a = '0; p_b = '0; p_cin = 1'b0; p_sub = 1'b0;
    accepted = 0; delivered = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    resetn = 1'b1;

    // 1 + 0xFFFFFFFF wraps to 0 with carry out, two cycles later
    a = 32'h0000_0001; b = 32'hFFFF_FFFF; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("lat_not_yet", out_valid, 0);
    cycle();
    check("dflt_valid", out_valid, 1);
    check("dflt_sum", sum, 32'h0);
    check("dflt_cout", cout, 1);
    check("dflt_ovf", ovf, 0);

    // 5 - 7 = -2, borrow (cout=0); cin ignored
    a = 32'd5; b = 32'd7; cin = 1'b1; sub = 1'b1; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("sub_valid", out_valid, 1);
    check("sub_sum", sum, 32'hFFFF_FFFE);
    check("sub_cout", cout, 0);

    // 0x80000000 - 1 overflows in two's complement
    a = 32'h8000_0000; b = 32'd1; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("ovfsub_sum", sum, 32'h7FFF_FFFF);
    check("ovfsub_cout", cout, 1);
`ifdef CLA_OVF_DETECT_EN
    check("ovfsub_ovf", ovf, 1);
`else
    check("ovfsub_ovf", ovf, 0);
`endif
    drain();

    // Streaming: 16 back-to-back vectors, no stall
    delivered = 0; accepted = 0;
    for (int i = 0; i < 16; i++) begin
      a = 32'h1357_9BDF * (i + 1); b = 32'hF0F0_0F0F ^ (32'h0101_0101 << i);
      cin = i[0]; sub = i[1]; in_valid = 1'b1;
      if (i == 3) begin a = 32'h7FFF_FFFF; b = 32'h0000_0001; sub = 1'b0; end
      if (i == 7) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; sub = 1'b0; end
      #1;
      check("stream_in_ready", in_ready, 1);
      cycle();
    end
    check("stream_lag", delivered, 14);
    drain();
    check("stream_total", delivered, 16);

    // Backpressure: 5 cycles of out_ready=0 with in_valid=1
    delivered = 0; accepted = 0; held = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = 32'h0000_1000 + i; b = 32'h0000_0100 * (i + 1); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      #1;
      check("bp_in_ready", in_ready, (i < 2) ? 1 : 0);
      if (i == 2) begin
        held = sum;
        check("bp_head", sum, 32'h0000_1100);
      end
      if (i > 2) check("bp_sum_stable", sum, held);
      cycle();
    end
    check("bp_accepts", accepted, 2);
    drain();
    check("bp_delivered", delivered, 2);

    // Reset with both stages full
    out_ready = 1'b0;
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    cycle(); cycle();
    in_valid = 1'b0;
    #1;
    check("mid_full", in_ready, 0);
    check("mid_pre_sum", sum, 32'h2345_6789);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    check("mid_out_valid", out_valid, 0);
    check("mid_sum", sum, 0);
    check("mid_in_ready", in_ready, 1);
    exp_q.delete();
    delivered = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    check("mid_no_ghost", delivered, 0);
    a = 32'd100; b = 32'd23; in_valid = 1'b1;
    cycle();
    drain();
    check("mid_recover", delivered, 1);

    // 16-bit / 4-bit-group instance, pseudo-random vectors against a+b+cin
    for (int i = 0; i < 1000; i++) begin
      p_a = 16'($urandom); p_b = 16'($urandom); p_cin = 1'($urandom); p_sub = 1'($urandom);
      if (i == 0) begin p_a = 16'hFFFF; p_b = 16'h0000; p_cin = 1'b1; p_sub = 1'b0; end
      p_in_valid = 1'b1;
      #1;
      if (p_out_valid) begin
        if (p_exp_q.size() == 0) check("p16_spurious", 1, 0);
        else check("p16_result", {p_cout, p_sum}, p_exp_q.pop_front());
      end
      if (p_in_ready) begin
        pb_eff = p_sub ? ~p_b : p_b;
        p_e    = {1'b0, p_a} + {1'b0, pb_eff} + {16'd0, (p_sub | p_cin)};
        p_exp_q.push_back(p_e);
      end
      @(posedge clock);
      #1;
    end
    p_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (p_out_valid && p_exp_q.size() > 0) check("p16_result", {p_cout, p_sum}, p_exp_q.pop_front());
      @(posedge clock);
      #1;
    end
    check("p16_drained", p_exp_q.size(), 0);
    check("p16_ovf_off", p_ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
